// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: widths, opcodes, phase
// numbers and the controller run state.
package cpu_pkg;

  localparam int OPCODE_W = 3;
  localparam int PHASE_W  = 3;
  localparam int ADDR_W   = 5;

  localparam logic [OPCODE_W-1:0] OP_HLT = 3'd0;
  localparam logic [OPCODE_W-1:0] OP_SKZ = 3'd1;
  localparam logic [OPCODE_W-1:0] OP_ADD = 3'd2;
  localparam logic [OPCODE_W-1:0] OP_AND = 3'd3;
  localparam logic [OPCODE_W-1:0] OP_XOR = 3'd4;
  localparam logic [OPCODE_W-1:0] OP_LDA = 3'd5;
  localparam logic [OPCODE_W-1:0] OP_STO = 3'd6;
  localparam logic [OPCODE_W-1:0] OP_JMP = 3'd7;

  localparam logic [PHASE_W-1:0] PH_INST_ADDR  = 3'd0;
  localparam logic [PHASE_W-1:0] PH_INST_FETCH = 3'd1;
  localparam logic [PHASE_W-1:0] PH_INST_LOAD  = 3'd2;
  localparam logic [PHASE_W-1:0] PH_IDLE       = 3'd3;
  localparam logic [PHASE_W-1:0] PH_OP_ADDR    = 3'd4;
  localparam logic [PHASE_W-1:0] PH_OP_FETCH   = 3'd5;
  localparam logic [PHASE_W-1:0] PH_ALU_OP     = 3'd6;
  localparam logic [PHASE_W-1:0] PH_STORE      = 3'd7;

  typedef enum logic {
    RUNNING = 1'b0,
    HALTED  = 1'b1
  } run_state_t;

  // Instructions whose operand comes from memory through the ALU.
  function automatic logic is_alu_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/cpu_phase_counter.sv
// Wrapping phase counter with a hold input and asynchronous active-high reset.
module cpu_phase_counter #(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             hold,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      count <= '0;
    else if (!hold)
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/cpu_controller.sv
// Eight-phase control sequencer: phase counter plus sticky halt flag, with all
// datapath strobes decoded combinationally from phase, opcode and Zero.
module cpu_controller #(
  parameter int OPCODE_W = 3,
  parameter int PHASE_W  = 3
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Zero,
  output logic [PHASE_W-1:0]  Phase,
  output logic                Sel,
  output logic                Rd,
  output logic                Ld_ir,
  output logic                Inc_pc,
  output logic                Ld_pc,
  output logic                Ld_ac,
  output logic                Wr,
  output logic                Data_e,
  output logic                Halt
);

  import cpu_pkg::*;

  if (OPCODE_W != 3 || PHASE_W != 3) begin : g_bad_width
    $error("cpu_controller: OPCODE_W and PHASE_W must both be 3");
  end

  run_state_t state_q;
  run_state_t state_next;
  logic       alu_op;

  assign alu_op = is_alu_op(Opcode);

  // The counter holds on the same edge that enters HALTED, so Phase sticks at 4.
  cpu_phase_counter #(.WIDTH(PHASE_W)) u_phase (
    .Clk   (Clk),
    .Reset (Reset),
    .hold  (state_next == HALTED),
    .count (Phase)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      state_q <= RUNNING;
    else
      state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    if (state_q == RUNNING && Phase == PH_OP_ADDR && Opcode == OP_HLT)
      state_next = HALTED;
  end

  // Once halted only Halt stays up; Inc_pc must not repeat while frozen in phase 4.
  always_comb begin
    Sel    = 1'b0;
    Rd     = 1'b0;
    Ld_ir  = 1'b0;
    Inc_pc = 1'b0;
    Ld_pc  = 1'b0;
    Ld_ac  = 1'b0;
    Wr     = 1'b0;
    Data_e = 1'b0;
    Halt   = 1'b0;
    if (state_q == HALTED) begin
      Halt = 1'b1;
    end else begin
      case (Phase)
        PH_INST_ADDR: begin
          Sel = 1'b1;
        end
        PH_INST_FETCH: begin
          Sel = 1'b1;
          Rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          Sel   = 1'b1;
          Rd    = 1'b1;
          Ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          Inc_pc = 1'b1;
          Halt   = (Opcode == OP_HLT);
        end
        PH_OP_FETCH: begin
          Rd = alu_op;
        end
        PH_ALU_OP: begin
          Rd     = alu_op;
          Inc_pc = (Opcode == OP_SKZ) && Zero;
          Ld_pc  = (Opcode == OP_JMP);
          Data_e = (Opcode == OP_STO);
        end
        PH_STORE: begin
          Rd     = alu_op;
          Ld_ac  = alu_op;
          Ld_pc  = (Opcode == OP_JMP);
          Wr     = (Opcode == OP_STO);
          Data_e = (Opcode == OP_STO);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: stimulus pushes reference-model
// expectations, a negedge monitor pops and compares them.
module tb_cpu_controller;

  typedef struct packed {
    logic [2:0] phase;
    logic       sel;
    logic       rd;
    logic       ld_ir;
    logic       inc_pc;
    logic       ld_pc;
    logic       ld_ac;
    logic       wr;
    logic       data_e;
    logic       halt;
  } outs_t;

  logic       Clk;
  logic       Reset;
  logic [2:0] Opcode;
  logic       Zero;
  logic [2:0] Phase;
  logic       Sel, Rd, Ld_ir, Inc_pc, Ld_pc, Ld_ac, Wr, Data_e, Halt;

  outs_t      exp_q[$];
  int         checks = 0;
  int         passes = 0;

  int         m_phase;
  bit         m_halted;
  logic [2:0] instr_op;

  cpu_controller dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Opcode (Opcode),
    .Zero   (Zero),
    .Phase  (Phase),
    .Sel    (Sel),
    .Rd     (Rd),
    .Ld_ir  (Ld_ir),
    .Inc_pc (Inc_pc),
    .Ld_pc  (Ld_pc),
    .Ld_ac  (Ld_ac),
    .Wr     (Wr),
    .Data_e (Data_e),
    .Halt   (Halt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference: which strobes each phase of an instruction raises.
  function automatic outs_t model_outs(input int ph, input logic [2:0] op,
                                       input logic z, input bit halted);
    outs_t o;
    bit    aluop;
    o     = '0;
    aluop = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    if (halted) begin
      o.phase = 3'd4;
      o.halt  = 1'b1;
      return o;
    end
    o.phase  = 3'(ph);
    o.sel    = (ph <= 3);
    o.rd     = (ph >= 1 && ph <= 3) || (ph >= 5 && aluop);
    o.ld_ir  = (ph == 2) || (ph == 3);
    o.inc_pc = (ph == 4) || (ph == 6 && op == 3'd1 && z);
    o.ld_pc  = (ph == 6 || ph == 7) && op == 3'd7;
    o.ld_ac  = (ph == 7) && aluop;
    o.wr     = (ph == 7) && op == 3'd6;
    o.data_e = (ph >= 6) && op == 3'd6;
    o.halt   = (ph == 4) && op == 3'd0;
    return o;
  endfunction

  task automatic push_expected();
    exp_q.push_back(model_outs(m_phase, Opcode, Zero, m_halted));
  endtask

  task automatic check_output(input outs_t exp);
    outs_t act;
    act = {Phase, Sel, Rd, Ld_ir, Inc_pc, Ld_pc, Ld_ac, Wr, Data_e, Halt};
    checks++;
    if (act === exp)
      passes++;
    else
      $display("[TB] FAIL outs @%0t: actual ph=%0d sel/rd/ir/inc/ldpc/ldac/wr/de/halt=%b required ph=%0d %b",
               $time, act.phase, act[8:0], exp.phase, exp[8:0]);
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() > 0)
      check_output(exp_q.pop_front());
  end

  // One clock: advance the model on the edge, then drive fresh inputs.
  // Opcode is only meaningful from phase 3 onward, so earlier phases get noise.
  task automatic apply_stimulus(input int zmode);
    @(posedge Clk);
    if (!m_halted) begin
      if (m_phase == 4 && Opcode == 3'd0)
        m_halted = 1'b1;
      else
        m_phase = (m_phase + 1) % 8;
    end
    #1;
    Opcode = (m_phase >= 3 || m_halted) ? instr_op : 3'($urandom_range(0, 7));
    Zero   = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
    push_expected();
  endtask

  task automatic run_instr(input logic [2:0] op, input int zmode);
    int n;
    instr_op = op;
    n = 0;
    do begin
      apply_stimulus(zmode);
      n++;
    end while (m_phase != 7 && !m_halted && n < 16);
  endtask

  task automatic apply_reset(input bit mid, input int hold);
    if (mid) begin
      @(negedge Clk);
      #1;
    end
    Reset    = 1'b1;
    m_phase  = 0;
    m_halted = 1'b0;
    push_expected();
    @(posedge Clk);
    #1;
    repeat (hold) begin
      @(posedge Clk);
      #1;
      push_expected();
    end
    Reset = 1'b0;
  endtask

  initial begin
    int n;
    Reset    = 1'b1;
    Opcode   = 3'd0;
    Zero     = 1'b0;
    instr_op = 3'd0;
    apply_reset(1'b0, 2);

    run_instr(3'd5, 0);
    run_instr(3'd6, 2);
    run_instr(3'd1, 1);
    run_instr(3'd1, 0);
    run_instr(3'd7, 2);
    run_instr(3'd2, 2);
    run_instr(3'd3, 2);
    run_instr(3'd4, 2);

    instr_op = 3'd6;
    n = 0;
    do begin
      apply_stimulus(2);
      n++;
    end while (m_phase != 5 && n < 16);
    apply_reset(1'b1, 1);

    repeat (20) run_instr(3'($urandom_range(1, 7)), 2);

    run_instr(3'd0, 2);
    repeat (22) apply_stimulus(2);
    apply_reset(1'b1, 1);
    run_instr(3'd5, 2);
    run_instr(3'd7, 2);

    @(negedge Clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: actual=running required=finished");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "[TB] timeout");
  end

endmodule
